// File: rtl/gmii_tx_pkg.sv
// Shared types and defaults for the GMII transmit frame scheduler.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    DRAIN,
    GAP
  } state_t;

  localparam int MIN_LEN_DEF = 60;
  localparam int MAX_LEN_DEF = 1514;
  localparam int GAP_DEF     = 16;

  localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/gmii_rr_arb2.sv
// Two-requester round-robin arbiter; the tie-break pointer advances only on update.
module gmii_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // Index of the requester that wins the next tie.
  logic prio_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      localparam logic ME = 1'(gi);
      assign gnt[gi] = req[gi] & (~req[1-gi] | (prio_reg == ME));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_reg <= 1'b0;
    end else if (update && (|gnt)) begin
      prio_reg <= gnt[0];
    end
  end

endmodule

// File: rtl/gmii_tx_sched.sv
// Frame scheduler ahead of the CRC appender: round-robin frame pull, pad to
// minimum, truncate oversize frames, and hold an FCS+IFG gap between frames.
module gmii_tx_sched
  import gmii_tx_pkg::*;
#(
  parameter int MIN_LEN    = MIN_LEN_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int GAP_CYCLES = GAP_DEF,
  parameter int CNT_W      = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       src0_req,
  input  logic [7:0] src0_data,
  input  logic       src0_last,
  output logic       src0_ready,
  input  logic       src1_req,
  input  logic [7:0] src1_data,
  input  logic       src1_last,
  output logic       src1_ready,
  output logic       out_dv,
  output logic [7:0] out_data,
  output logic [1:0] grant,
  output logic       busy,
  output logic       frame_done,
  output logic       trunc_err
);

  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam logic [CNT_W-1:0] MIN_N    = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_N    = CNT_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] byte_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       arb_gnt;
  logic             arb_update;
  logic             consuming;
  logic [7:0]       cur_data;
  logic             cur_last;

  assign cnt_next   = byte_cnt_reg + 1'b1;
  assign arb_update = (state_reg == IDLE) && (src0_req || src1_req);
  assign consuming  = (state_reg == DATA) || (state_reg == DRAIN);
  assign src0_ready = consuming && grant[0];
  assign src1_ready = consuming && grant[1];
  assign cur_data   = grant[1] ? src1_data : src0_data;
  assign cur_last   = grant[1] ? src1_last : src0_last;
  assign busy       = (state_reg != IDLE);

  gmii_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({src1_req, src0_req}),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    trunc_err  <= 1'b0;
    if (!rst) begin
      state_reg    <= IDLE;
      grant        <= 2'b00;
      out_dv       <= 1'b0;
      out_data     <= PAD_BYTE;
      byte_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          out_dv       <= 1'b0;
          out_data     <= PAD_BYTE;
          byte_cnt_reg <= '0;
          gap_cnt_reg  <= '0;
          if (arb_update) begin
            grant     <= arb_gnt;
            state_reg <= DATA;
          end
        end
        DATA: begin
          out_dv       <= 1'b1;
          out_data     <= cur_data;
          byte_cnt_reg <= cnt_next;
          // last wins over the length limit, so an exact MAX_LEN frame is not truncated
          if (cur_last) begin
            if (cnt_next < MIN_N) begin
              state_reg <= PAD;
            end else begin
              state_reg   <= GAP;
              grant       <= 2'b00;
              gap_cnt_reg <= '0;
              frame_done  <= 1'b1;
            end
          end else if (cnt_next == MAX_N) begin
            state_reg <= DRAIN;
            trunc_err <= 1'b1;
          end
        end
        PAD: begin
          out_dv       <= 1'b1;
          out_data     <= PAD_BYTE;
          byte_cnt_reg <= cnt_next;
          if (cnt_next == MIN_N) begin
            state_reg   <= GAP;
            grant       <= 2'b00;
            gap_cnt_reg <= '0;
            frame_done  <= 1'b1;
          end
        end
        DRAIN: begin
          out_dv   <= 1'b0;
          out_data <= PAD_BYTE;
          if (cur_last) begin
            state_reg   <= GAP;
            grant       <= 2'b00;
            gap_cnt_reg <= '0;
            frame_done  <= 1'b1;
          end
        end
        GAP: begin
          out_dv   <= 1'b0;
          out_data <= PAD_BYTE;
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant     <= 2'b00;
          out_dv    <= 1'b0;
          out_data  <= PAD_BYTE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed bench for gmii_tx_sched: cycle-stepped source models plus per-scenario checks.
`timescale 1ns/1ps
module tb_gmii_tx_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       src0_req = 1'b0, src0_last = 1'b0, src1_req = 1'b0, src1_last = 1'b0;
  logic [7:0] src0_data = 8'h00, src1_data = 8'h00;
  logic       src0_ready, src1_ready, out_dv, busy, frame_done, trunc_err;
  logic [7:0] out_data;
  logic [1:0] grant;

  always #5 clk = ~clk;

  gmii_tx_sched #(.MIN_LEN(60), .MAX_LEN(1514), .GAP_CYCLES(16), .CNT_W(11)) dut (
    .clk(clk), .rst(rst),
    .src0_req(src0_req), .src0_data(src0_data), .src0_last(src0_last), .src0_ready(src0_ready),
    .src1_req(src1_req), .src1_data(src1_data), .src1_last(src1_last), .src1_ready(src1_ready),
    .out_dv(out_dv), .out_data(out_data), .grant(grant), .busy(busy),
    .frame_done(frame_done), .trunc_err(trunc_err)
  );

  int nvec = 0, nerr = 0, cyc = 0;
  int len[2], idx[2], left[2], fid[2];
  bit act[2];
  logic [7:0] base[2];
  logic [7:0] cap_q[$];
  int gap_q[$];
  logic [1:0] grant_q[$];
  int fd_cnt, te_cnt, fd_cyc, te_cyc, first_dv_cyc, last_dv_cyc, max_run, run, zero_run;
  int rdy_cnt[2];
  bit seen_dv;
  logic [1:0] prev_grant;

  function automatic logic [7:0] gen(int s, int f, int i);
    logic [7:0] b;
    b = base[s] + 8'(f * 17) + 8'(i);
    return b;
  endfunction

  task automatic drive();
    src0_req  = act[0];
    src0_data = act[0] ? gen(0, fid[0], idx[0]) : 8'h00;
    src0_last = act[0] && (idx[0] == len[0] - 1);
    src1_req  = act[1];
    src1_data = act[1] ? gen(1, fid[1], idx[1]) : 8'h00;
    src1_last = act[1] && (idx[1] == len[1] - 1);
  endtask

  task automatic start(input int s, input int l, input int c);
    len[s] = l; idx[s] = 0; left[s] = c; fid[s] = 0; act[s] = 1'b1;
    drive();
  endtask

  task automatic advance(input int s);
    if (idx[s] == len[s] - 1) begin
      idx[s] = 0; fid[s]++; left[s]--;
      if (left[s] <= 0) act[s] = 1'b0;
    end else begin
      idx[s]++;
    end
  endtask

  task automatic clear_cap();
    cap_q.delete(); gap_q.delete(); grant_q.delete();
    fd_cnt = 0; te_cnt = 0; fd_cyc = -1; te_cyc = -1; first_dv_cyc = -1; last_dv_cyc = -1;
    max_run = 0; run = 0; zero_run = 0; seen_dv = 1'b0; prev_grant = grant;
    rdy_cnt[0] = 0; rdy_cnt[1] = 0;
  endtask

  // One clock: sources advance on accepted bytes, outputs are observed 1 ns after the edge.
  task automatic step();
    bit a0, a1;
    a0 = src0_ready && src0_req;
    a1 = src1_ready && src1_req;
    @(posedge clk); #1;
    cyc++;
    if (a0) advance(0);
    if (a1) advance(1);
    drive();
    if (out_dv) begin
      if (seen_dv && zero_run > 0) gap_q.push_back(zero_run);
      if (first_dv_cyc < 0) first_dv_cyc = cyc;
      last_dv_cyc = cyc; seen_dv = 1'b1; zero_run = 0; run++;
      if (run > max_run) max_run = run;
      cap_q.push_back(out_data);
    end else begin
      run = 0;
      if (seen_dv) zero_run++;
    end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (trunc_err) begin te_cnt++; te_cyc = cyc; end
    if (grant != 2'b00 && prev_grant == 2'b00) grant_q.push_back(grant);
    prev_grant = grant;
    rdy_cnt[0] += int'(src0_ready);
    rdy_cnt[1] += int'(src1_ready);
  endtask

  task automatic test_reset();
    rst = 1'b0; drive();
    repeat (3) step();
    nvec++; if (out_dv !== 1'b0) begin nerr++; $display("FAIL reset_dv: got %b want 0", out_dv); end
    nvec++; if (out_data !== 8'h00) begin nerr++; $display("FAIL reset_data: got %h want 00", out_data); end
    nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL reset_grant: got %b want 00", grant); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nvec++; if ({frame_done, trunc_err} !== 2'b00) begin nerr++; $display("FAIL reset_pulses: got %b want 00", {frame_done, trunc_err}); end
    nvec++; if ({src1_ready, src0_ready} !== 2'b00) begin nerr++; $display("FAIL reset_ready: got %b want 00", {src1_ready, src0_ready}); end
    rst = 1'b1;
    step();
    $display("reset: dv=%b grant=%b busy=%b", out_dv, grant, busy);
  endtask

  task automatic test_single_frame();
    int t0, bad;
    clear_cap(); t0 = cyc;
    start(0, 64, 1);
    repeat (90) step();
    bad = 0;
    for (int i = 0; i < cap_q.size() && i < 64; i++) if (cap_q[i] !== gen(0, 0, i)) bad++;
    nvec++; if (cap_q.size() != 64) begin nerr++; $display("FAIL single_len: got %0d want 64", cap_q.size()); end
    nvec++; if (max_run != 64) begin nerr++; $display("FAIL single_run: got %0d want 64", max_run); end
    nvec++; if (first_dv_cyc - t0 != 2) begin nerr++; $display("FAIL single_latency: got %0d want 2", first_dv_cyc - t0); end
    nvec++; if (bad != 0) begin nerr++; $display("FAIL single_data: got %0d bad bytes want 0", bad); end
    nvec++; if (grant_q.size() != 1 || grant_q[0] !== 2'b01) begin nerr++; $display("FAIL single_grant: got %0d grants first %b want 1 x 01", grant_q.size(), grant_q.size() > 0 ? grant_q[0] : 2'bxx); end
    nvec++; if (fd_cnt != 1) begin nerr++; $display("FAIL single_done: got %0d want 1", fd_cnt); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    $display("single: %0d bytes, latency %0d, done pulses %0d", cap_q.size(), first_dv_cyc - t0, fd_cnt);
  endtask

  task automatic test_short_frame();
    int zeros;
    clear_cap();
    base[1] = 8'hAB;
    start(1, 1, 1);
    repeat (90) step();
    zeros = 0;
    for (int i = 1; i < cap_q.size(); i++) if (cap_q[i] === 8'h00) zeros++;
    nvec++; if (cap_q.size() != 60) begin nerr++; $display("FAIL short_len: got %0d want 60", cap_q.size()); end
    nvec++; if (cap_q.size() == 0 || cap_q[0] !== 8'hAB) begin nerr++; $display("FAIL short_first: got %h want AB", cap_q.size() > 0 ? cap_q[0] : 8'hxx); end
    nvec++; if (zeros != 59) begin nerr++; $display("FAIL short_pad: got %0d want 59", zeros); end
    nvec++; if (rdy_cnt[1] != 1) begin nerr++; $display("FAIL short_ready: got %0d want 1", rdy_cnt[1]); end
    nvec++; if (grant_q.size() != 1 || grant_q[0] !== 2'b10) begin nerr++; $display("FAIL short_grant: got %0d grants want 1 x 10", grant_q.size()); end
    $display("short: %0d bytes, pad %0d, ready cycles %0d", cap_q.size(), zeros, rdy_cnt[1]);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    int bad_gap, bad_g, bad;
    clear_cap();
    base[0] = 8'h10; base[1] = 8'h90;
    start(0, 60, 2);
    start(1, 60, 2);
    repeat (330) step();
    bad_gap = 0; bad_g = 0; bad = 0;
    foreach (gap_q[i]) if (gap_q[i] != 17) bad_gap++;
    foreach (grant_q[i]) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      if (grant_q[i] !== exp_g) bad_g++;
    end
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 60; i++)
        if (k * 60 + i < cap_q.size() && cap_q[k * 60 + i] !== gen(k % 2, k / 2, i)) bad++;
    nvec++; if (grant_q.size() != 4 || bad_g != 0) begin nerr++; $display("FAIL b2b_grants: got %0d grants %0d wrong want 4 alternating", grant_q.size(), bad_g); end
    nvec++; if (gap_q.size() != 3 || bad_gap != 0) begin nerr++; $display("FAIL b2b_gaps: got %0d gaps %0d not 17 want 3 x 17", gap_q.size(), bad_gap); end
    nvec++; if (cap_q.size() != 240 || bad != 0) begin nerr++; $display("FAIL b2b_data: got %0d bytes %0d bad want 240 0", cap_q.size(), bad); end
    nvec++; if (fd_cnt != 4) begin nerr++; $display("FAIL b2b_done: got %0d want 4", fd_cnt); end
    $display("b2b: %0d grants, %0d gaps, %0d bytes", grant_q.size(), gap_q.size(), cap_q.size());
  endtask

  task automatic test_truncate();
    int bad;
    clear_cap();
    start(0, 1600, 1);
    repeat (1640) step();
    bad = 0;
    for (int i = 0; i < cap_q.size() && i < 1514; i++) if (cap_q[i] !== gen(0, 0, i)) bad++;
    nvec++; if (cap_q.size() != 1514 || bad != 0) begin nerr++; $display("FAIL trunc_data: got %0d bytes %0d bad want 1514 0", cap_q.size(), bad); end
    nvec++; if (te_cnt != 1) begin nerr++; $display("FAIL trunc_pulse: got %0d want 1", te_cnt); end
    nvec++; if (te_cyc != last_dv_cyc) begin nerr++; $display("FAIL trunc_when: got cycle %0d want %0d", te_cyc, last_dv_cyc); end
    nvec++; if (rdy_cnt[0] != 1600) begin nerr++; $display("FAIL trunc_ready: got %0d want 1600", rdy_cnt[0]); end
    nvec++; if (fd_cnt != 1 || fd_cyc - te_cyc != 86) begin nerr++; $display("FAIL trunc_gap: got %0d pulses offset %0d want 1 86", fd_cnt, fd_cyc - te_cyc); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL trunc_idle: got busy=%b want 0", busy); end
    $display("trunc: %0d bytes out, trunc pulses %0d, ready cycles %0d", cap_q.size(), te_cnt, rdy_cnt[0]);
  endtask

  task automatic test_exact_max();
    int bad;
    clear_cap();
    start(0, 1514, 1);
    repeat (1550) step();
    bad = 0;
    for (int i = 0; i < cap_q.size() && i < 1514; i++) if (cap_q[i] !== gen(0, 0, i)) bad++;
    nvec++; if (cap_q.size() != 1514 || bad != 0) begin nerr++; $display("FAIL max_data: got %0d bytes %0d bad want 1514 0", cap_q.size(), bad); end
    nvec++; if (te_cnt != 0) begin nerr++; $display("FAIL max_trunc: got %0d want 0", te_cnt); end
    nvec++; if (fd_cnt != 1 || fd_cyc != last_dv_cyc) begin nerr++; $display("FAIL max_done: got %0d pulses at %0d want 1 at %0d", fd_cnt, fd_cyc, last_dv_cyc); end
    $display("max: %0d bytes, trunc pulses %0d", cap_q.size(), te_cnt);
  endtask

  task automatic test_reset_midframe();
    int guard;
    clear_cap();
    start(0, 100, 1);
    guard = 0;
    while (cap_q.size() < 30 && guard < 60) begin step(); guard++; end
    nvec++; if (cap_q.size() != 30) begin nerr++; $display("FAIL midrst_reach: got %0d bytes want 30", cap_q.size()); end
    rst = 1'b0; act[0] = 1'b0; drive();
    step();
    nvec++; if (out_dv !== 1'b0) begin nerr++; $display("FAIL midrst_dv: got %b want 0", out_dv); end
    nvec++; if (grant !== 2'b00) begin nerr++; $display("FAIL midrst_grant: got %b want 00", grant); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy: got %b want 0", busy); end
    step();
    clear_cap();
    rst = 1'b1;
    start(0, 20, 1);
    start(1, 20, 1);
    step();
    nvec++; if (grant !== 2'b01) begin nerr++; $display("FAIL midrst_first: got %b want 01", grant); end
    repeat (180) step();
    nvec++; if (grant_q.size() != 2 || cap_q.size() != 120) begin nerr++; $display("FAIL midrst_after: got %0d grants %0d bytes want 2 120", grant_q.size(), cap_q.size()); end
    $display("midrst: restart grants %0d, bytes %0d", grant_q.size(), cap_q.size());
  endtask

  initial begin
    base[0] = 8'h10; base[1] = 8'h90;
    act[0] = 1'b0; act[1] = 1'b0;
    len[0] = 1; len[1] = 1; idx[0] = 0; idx[1] = 0; fid[0] = 0; fid[1] = 0; left[0] = 0; left[1] = 0;
    test_reset();
    test_single_frame();
    test_short_frame();
    test_back_to_back();
    test_truncate();
    test_exact_max();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/gmii_tx_sched.md
Name: gmii_tx_sched

Overview:
- Frame-level scheduler in front of the GMII CRC32 appender.
- Arbitrates round-robin between two byte-stream frame sources and pulls one whole frame at a time.
- Pads short frames to the Ethernet minimum (pre-FCS) and truncates oversize frames.
- Enforces an idle gap long enough for the appender to emit its 4 FCS bytes, restore its CRC register to all-ones, and honour the 12-byte IFG.

Parameters:
- MIN_LEN, 60, minimum body bytes per frame before FCS; shorter frames are zero-padded.
- MAX_LEN, 1514, maximum body bytes; longer frames are truncated.
- GAP_CYCLES, 16, cycles spent in GAP after each frame (4 FCS + 12 IFG); legal range is >= 4.
- CNT_W, 11, byte-counter width; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- src0_req  in  1  source 0 has a frame ready; must be held until its last byte is accepted.
- src0_data  in  8  source 0 current byte; valid every cycle while src0_req=1 (no bubbles).
- src0_last  in  1  marks src0_data as the final byte of the frame.
- src0_ready  out  1  combinational; the byte is consumed this cycle.
- src1_req, src1_data, src1_last, src1_ready  same as source 0.
- out_dv  out  1  registered; to the CRC appender's dv input.
- out_data  out  8  registered; to the CRC appender's data input.
- grant  out  2  one-hot owner of the current frame; 00 when not in DATA, PAD or DRAIN.
- busy  out  1  1 in any state other than IDLE.
- frame_done  out  1  one-cycle pulse on entry to GAP.
- trunc_err  out  1  one-cycle pulse when a frame reaches MAX_LEN without last.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - out_dv=0, out_data=8'h00, grant=00, busy=0, frame_done=0, trunc_err=0, srcX_ready=0.
  - Byte counter and gap counter clear.
  - The round-robin pointer is set so source 0 wins the first tie.
  - Reset mid-frame abandons the frame immediately, with out_dv=0 from the next cycle. The source must drop its request itself.
- IDLE:
  - If any srcX_req=1, pick a winner and register grant. The next state is DATA.
  - Winner selection: the sole requester, or on a tie the source that did not win last time.
  - The pointer updates only at grant.
  - srcX_req is sampled only in IDLE.
- DATA:
  - The granted srcX_ready is 1 every cycle; the other ready is 0.
  - The accepted byte appears on out_data with out_dv=1 one cycle later, so latency is 1.
  - The counter increments per accepted byte. Call the value after increment n.
  - last=1 with n < MIN_LEN goes to PAD.
  - last=1 with n >= MIN_LEN goes to GAP.
  - last=0 with n == MAX_LEN goes to DRAIN and pulses trunc_err.
  - A source dropping req mid-frame is a protocol violation. The scheduler keeps consuming regardless.
- PAD:
  - srcX_ready=0; emit 8'h00 with out_dv=1 and keep incrementing the counter.
  - When n == MIN_LEN, go to GAP.
  - A 1-byte frame gives exactly 59 pad bytes.
- DRAIN:
  - Granted ready stays 1 and bytes are discarded, with out_dv=0.
  - When last=1 is accepted, go to GAP.
  - The FCS covers only the first MAX_LEN bytes.
- GAP:
  - out_dv=0, out_data=8'h00.
  - Stay for exactly GAP_CYCLES cycles, then return to IDLE.
- Back-to-back frames with requests continuously pending:
  - out_dv=0 for exactly GAP_CYCLES+1 consecutive cycles between the last body byte and the next first byte.
  - This is GAP_CYCLES cycles in GAP plus 1 cycle in IDLE.
- A frame whose last byte lands at n == MAX_LEN is accepted normally, with no truncation.
- Simultaneous last and MAX_LEN: last takes priority, so the next state is GAP.

Decomposition:
- Package gmii_tx_pkg holds:
  - the state enum (IDLE, DATA, PAD, DRAIN, GAP);
  - constants MIN_LEN_DEF=60, MAX_LEN_DEF=1514, GAP_DEF=16;
  - the pad byte 8'h00.
- One sub-module, gmii_rr_arb2: a 2-requester round-robin arbiter with inputs req[1:0] and update, outputting a one-hot gnt. It is shared with the future RX/loopback muxes.

Test Plan:
- Single 64-byte frame on src0 -> out_dv high for 64 consecutive cycles, starting 2 cycles after src0_req rises. Data matches input, grant=01, frame_done pulses once.
- 1-byte frame (0xAB) on src1 -> out shows AB followed by 59 bytes of 00, for 60 dv cycles total. src1_ready is high for exactly 1 cycle.
- src0 and src1 both request continuously with 60-byte frames -> grants alternate 01,10,01,10. Each inter-frame out_dv=0 gap is exactly 17 cycles.
- 1600-byte frame on src0 -> 1514 dv cycles and a trunc_err pulse when byte 1514 is consumed. src0_ready stays high until the last byte (1600); GAP follows.
- Reset asserted at byte 30 of a frame -> out_dv=0, grant=00, busy=0 on the next cycle. After release with both requesting, src0 is granted first.
- Frame of exactly 1514 bytes with last on byte 1514 -> no trunc_err, 1514 dv cycles, then GAP.
